// File: rtl/rol5_pkg.sv
// Shared types and constants for the rol_5bit_seq rotate unit.
// The optional direction select is controlled in the top by ROL5_DIR_SEL_EN.
package rol5_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROT  = 2'd1,
      DONE = 2'd2
   } rol_state_e;

   localparam int DATA_W_DEF = 5;
   localparam int SHIFT_W    = 3;

   // Rotating by DATA_W positions is the identity, so only the remainder matters.
   function automatic logic [SHIFT_W-1:0] mod_count(input logic [SHIFT_W-1:0] s,
                                                    input int w);
      return SHIFT_W'(int'(s) % w);
   endfunction

endpackage

// File: rtl/rot_step_1bit.sv
// Combinational single-position rotate; dir_i=0 rotates left, dir_i=1 rotates right.
module rot_step_1bit #(
   parameter int W = 5
) (
   input  logic [W-1:0] data_i,
   input  logic         dir_i,
   output logic [W-1:0] data_o,
   output logic         out_bit_o
);

   assign data_o    = dir_i ? {data_i[0], data_i[W-1:1]} : {data_i[W-2:0], data_i[W-1]};
   assign out_bit_o = dir_i ? data_i[0] : data_i[W-1];

endmodule

// File: rtl/rol_5bit_seq.sv
// Multi-cycle rotate unit: one bit per clock for (shift mod DATA_W) cycles, then a done pulse.
// Define ROL5_DIR_SEL_EN to add the dir input (1 = rotate right).
module rol_5bit_seq
   import rol5_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
`ifdef ROL5_DIR_SEL_EN
   input  logic               dir,
`endif
   input  logic [DATA_W-1:0]  a,
   input  logic [SHIFT_W-1:0] shift,
   output logic               busy,
   output logic               done,
   output logic [DATA_W-1:0]  z,
   output logic               cf,
   output logic               sf,
   output logic               zf,
   output logic [1:0]         dbg_state_o
);

   // Handshake: start is sampled only in IDLE or DONE; done is high for the single
   // cycle spent in DONE, and z/flags stay valid from then until the next done.

   rol_state_e         state_q, state_d;
   logic [DATA_W-1:0]  work_q, work_d;
   logic [SHIFT_W-1:0] cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               busy_q, busy_d;
   logic [DATA_W-1:0]  z_q, z_d;
   logic               cf_q, cf_d;
   logic               sf_q, sf_d;
   logic               zf_q, zf_d;
   logic               accept;
   logic               dir_in;
   logic [SHIFT_W-1:0] cnt_start;
   logic [DATA_W-1:0]  rot_data;
   logic               rot_bit;

`ifdef ROL5_DIR_SEL_EN
   assign dir_in = dir;
`else
   assign dir_in = 1'b0;
`endif

   assign cnt_start = mod_count(shift, DATA_W);

   rot_step_1bit #(.W(DATA_W)) u_step (
      .data_i    (work_q),
      .dir_i     (dir_q),
      .data_o    (rot_data),
      .out_bit_o (rot_bit)
   );

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      z_d     = z_q;
      cf_d    = cf_q;
      accept  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               accept = 1'b1;
               work_d = a;
               cnt_d  = cnt_start;
               dir_d  = dir_in;
               if (cnt_start == '0) begin
                  state_d = DONE;
                  z_d     = a;
                  cf_d    = 1'b0;
               end else begin
                  state_d = ROT;
               end
            end
         end
         ROT: begin
            work_d = rot_data;
            cnt_d  = cnt_q - SHIFT_W'(1);
            if (cnt_q == SHIFT_W'(1)) begin
               state_d = DONE;
               z_d     = rot_data;
               cf_d    = rot_bit;
            end
         end
         default: state_d = IDLE;
      endcase
      // Flags follow the value being registered into z, not the work register.
      sf_d   = z_d[DATA_W-1];
      zf_d   = (z_d == '0);
      busy_d = accept | (state_d == ROT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         z_q     <= '0;
         cf_q    <= 1'b0;
         sf_q    <= 1'b0;
         zf_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         z_q     <= z_d;
         cf_q    <= cf_d;
         sf_q    <= sf_d;
         zf_q    <= zf_d;
      end
   end

   assign busy        = busy_q;
   assign done        = (state_q == DONE);
   assign z           = z_q;
   assign cf          = cf_q;
   assign sf          = sf_q;
   assign zf          = zf_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rol_5bit_seq.sv
// Scoreboard bench for rol_5bit_seq: driver pushes model results, monitor checks on done.
module tb_rol_5bit_seq;

   localparam int W = 5;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         dir;
   logic [W-1:0] a;
   logic [2:0]   shift;
   logic         busy, done, cf, sf, zf;
   logic [W-1:0] z;
   logic [1:0]   dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [W+2:0] exp_q[$];
   int           exp_cyc_q[$];
   logic [W-1:0] last_z = '0;

   rol_5bit_seq #(.DATA_W(W)) dut (
`ifdef ROL5_DIR_SEL_EN
      .dir         (dir),
`endif
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .shift       (shift),
      .busy        (busy),
      .done        (done),
      .z           (z),
      .cf          (cf),
      .sf          (sf),
      .zf          (zf),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: rotation as shift-and-or arithmetic; packs {zf, sf, cf, z}.
   function automatic logic [W+2:0] model(input logic [W-1:0] av, input int s, input logic d);
      int     k = s % W;
      longint m = (longint'(1) << W) - 1;
      longint x = longint'(av);
      longint r;
      logic   c;
      logic [W-1:0] zz;
      if (k == 0) begin
         r = x;
         c = 1'b0;
      end else if (!d) begin
         r = ((x << k) | (x >> (W - k))) & m;
         c = ((x >> (W - k)) & 1) != 0;
      end else begin
         r = ((x >> k) | (x << (W - k))) & m;
         c = ((x >> (k - 1)) & 1) != 0;
      end
      zz = r[W-1:0];
      return {zz == '0, zz[W-1], c, zz};
   endfunction

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Driver: called at a negedge where the DUT is ready; returns at the negedge of
   // the DONE cycle so a following call is back-to-back.
   task automatic issue(input logic [W-1:0] av, input int s, input logic d, input bit poke);
      int k = s % W;
      a     = av;
      shift = 3'(s);
      dir   = d;
      start = 1'b1;
`ifdef ROL5_DIR_SEL_EN
      exp_q.push_back(model(av, s, d));
`else
      exp_q.push_back(model(av, s, 1'b0));
`endif
      exp_cyc_q.push_back(cyc + 1 + k);
      @(negedge clk);
      check("busy_after_accept", int'(busy), 1);
      if (poke && k > 0) begin
         start = 1'b1;
         a     = '1;
         shift = 3'($urandom_range(0, 7));
      end else begin
         start = 1'b0;
      end
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      if (k > 0) check("busy_in_done", int'(busy), 0);
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pops on each done and tracks that z holds in between.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done z=%0h", z);
            end else begin
               logic [W+2:0] e;
               int           ec;
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               check("z", int'(z), int'(e[W-1:0]));
               check("cf", int'(cf), int'(e[W]));
               check("sf", int'(sf), int'(e[W+1]));
               check("zf", int'(zf), int'(e[W+2]));
               check("done_cycle", cyc, ec);
               last_z = e[W-1:0];
            end
         end else begin
            check("z_hold", int'(z), int'(last_z));
         end
      end
   end

   initial begin
      int ks;
      rst_n = 1'b0;
      start = 1'b0;
      dir   = 1'b0;
      a     = '0;
      shift = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_z", int'(z), 0);
      check("rst_cf", int'(cf), 0);
      check("rst_sf", int'(sf), 0);
      check("rst_zf", int'(zf), 1);
      check("rst_state", int'(dbg_state), 0);
      rst_n = 1'b1;
      idle(2);

      // directed cases
      issue(5'b00001, 1, 1'b0, 1'b0); idle(1);
      issue(5'b10000, 1, 1'b0, 1'b0); idle(1);
      issue(5'b01000, 1, 1'b0, 1'b0); idle(1);
      issue(5'b10110, 0, 1'b0, 1'b0); idle(1);
      issue(5'b10110, 5, 1'b0, 1'b0); idle(1);
      issue(5'b00011, 7, 1'b0, 1'b1);
      issue(5'b00000, 3, 1'b0, 1'b0);
      issue(5'b11111, 4, 1'b0, 1'b0); idle(1);
`ifdef ROL5_DIR_SEL_EN
      issue(5'b00001, 1, 1'b1, 1'b0); idle(1);
`endif

      // random traffic with back-to-back starts, gaps and ignored pokes
      for (int i = 0; i < 60; i++) begin
         issue(W'($urandom_range(0, (1 << W) - 1)), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 2));
      end
      idle(3);

      // reset in the second ROT cycle discards the operation
      ks    = 4;
      a     = 5'b00001;
      shift = 3'(ks);
      dir   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2;
      rst_n  = 1'b0;
      last_z = '0;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_z", int'(z), 0);
      check("midrst_zf", int'(zf), 1);
      check("midrst_state", int'(dbg_state), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(10);

      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
